// File: rtl/data_ram_target_pkg.sv
// Shared definitions for the data-RAM target: size codes, FSM states, memory-map
// constants and the byte-lane helpers used for write steering and read extraction.
package data_ram_target_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    localparam logic [31:0] DRAM_BASE      = 32'h0000_1000;
    localparam int          DRAM_ADDR_BITS = 12;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return off[0];
            SIZE_WORD: return off != 2'b00;
            default:   return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SIZE_BYTE: return 4'b0001 << off;
            SIZE_HALF: return off[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: return 4'b1111;
            default:   return 4'b0000;
        endcase
    endfunction

    // Replicating the narrow datum across the word lets the byte enables pick the lane.
    function automatic logic [31:0] lane_replicate(input logic [1:0] size, input logic [31:0] data);
        case (size)
            SIZE_BYTE: return {4{data[7:0]}};
            SIZE_HALF: return {2{data[15:0]}};
            default:   return data;
        endcase
    endfunction

    function automatic logic [31:0] lane_extract(input logic [1:0] size, input logic [1:0] off,
                                                 input logic [31:0] word);
        logic [31:0] shifted;
        shifted = word >> {off, 3'b000};
        case (size)
            SIZE_BYTE: return {24'b0, shifted[7:0]};
            SIZE_HALF: return {16'b0, shifted[15:0]};
            SIZE_WORD: return word;
            default:   return 32'b0;
        endcase
    endfunction

endpackage

// File: rtl/data_ram_target_bank.sv
// Word-organised storage with four byte-enabled lanes; synchronous write and
// registered read. Contents are intentionally not reset.
module data_ram_bank #(
    parameter int WORD_BITS = 10
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [3:0]           be_i,
    input  logic [WORD_BITS-1:0] waddr_i,
    input  logic [31:0]          wdata_i,
    input  logic [WORD_BITS-1:0] raddr_i,
    output logic [31:0]          rdata_o
);

    logic [3:0][7:0] mem_q [2**WORD_BITS];
    logic [31:0]     rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) mem_q[waddr_i][i] <= wdata_i[8*i +: 8];
            end
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_ram_target.sv
// Bus target for the data RAM: decodes its address window, checks size/alignment,
// sequences IDLE/WAIT/ACCESS/DONE and steers byte lanes to and from the bank.
module data_ram_target
    import data_ram_target_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DRAM_BASE,
    parameter int          ADDR_BITS   = DRAM_ADDR_BITS,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wd,
    input  logic        rd,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic        err,
    output state_e      dbg_state
);

    localparam int         WORD_BITS = ADDR_BITS - 2;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

    state_e                 state_q, state_d;
    logic [3:0]             wcnt_q, wcnt_d;
    logic [ADDR_BITS-1:0]   off_q, off_d;
    logic [1:0]             size_q, size_d;
    logic [31:0]            wdata_q, wdata_d;
    logic                   wr_q, wr_d;
    logic                   err_q, err_d;
    logic [31:0]            rdata_q, rdata_d;

    logic [31:0]            offset;
    logic                   in_range;
    logic                   illegal;
    logic [WORD_BITS-1:0]   bank_raddr;
    logic [31:0]            bank_rdata;
    logic                   bank_we;

    assign offset   = addr - BASE_ADDR;
    assign in_range = (addr >= BASE_ADDR) && (offset[31:ADDR_BITS] == '0);
    assign illegal  = (wd & rd) | misaligned(size, addr[1:0]);

    // In IDLE the bank is addressed straight from the bus so the word is already
    // registered by the time ACCESS runs, even with zero wait states.
    assign bank_raddr = (state_q == ST_IDLE) ? offset[ADDR_BITS-1:2] : off_q[ADDR_BITS-1:2];
    assign bank_we    = (state_q == ST_ACCESS) && wr_q && !rst;

    data_ram_bank #(.WORD_BITS(WORD_BITS)) u_bank (
        .clk_i   (clk),
        .we_i    (bank_we),
        .be_i    (lane_enables(size_q, off_q[1:0])),
        .waddr_i (off_q[ADDR_BITS-1:2]),
        .wdata_i (lane_replicate(size_q, wdata_q)),
        .raddr_i (bank_raddr),
        .rdata_o (bank_rdata)
    );

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        off_d   = off_q;
        size_d  = size_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if ((wd | rd) && in_range) begin
                    off_d   = offset[ADDR_BITS-1:0];
                    size_d  = size;
                    wdata_d = wdata;
                    wr_d    = wd;
                    err_d   = illegal;
                    if (illegal) begin
                        state_d = ST_DONE;
                    end else if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        wcnt_d  = WAIT_LOAD;
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_WAIT: begin
                if (wcnt_q == 4'd0) state_d = ST_ACCESS;
                else                wcnt_d  = wcnt_q - 4'd1;
            end
            ST_ACCESS: begin
                state_d = ST_DONE;
                if (!wr_q) rdata_d = lane_extract(size_q, off_q[1:0], bank_rdata);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            wcnt_q  <= '0;
            off_q   <= '0;
            size_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            off_q   <= off_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata     = rdata_q;
    assign ready     = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_WAIT) || (state_q == ST_ACCESS);
    assign done      = (state_q == ST_DONE) && !err_q;
    assign err       = (state_q == ST_DONE) && err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_data_ram_target.sv
// Randomised scoreboard bench for data_ram_target: a byte-addressed memory model
// predicts each response (kind, cycle, rdata) and a monitor checks what the DUT presents.
// Handshake: a request is presented while ready=1 and is taken on that rising edge;
// exactly one done or err pulse follows for every in-range request.
module tb_data_ram_target;
    import data_ram_target_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int          WS   = 1;
    localparam int          EW   = 49;   // {cycle[15:0], is_err, rdata[31:0]}

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wd = 1'b0, rd = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rdata;
    logic        ready, busy, done, err;
    state_e      dbg_state;

    logic        rd0 = 1'b0;
    logic [31:0] rdata0;
    logic        ready0, busy0, done0, err0;
    state_e      dbg_state0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [EW-1:0] exp_q[$];
    logic [7:0]    model_mem [4096];
    logic [31:0]   last_rd = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_ram_target #(.BASE_ADDR(BASE), .ADDR_BITS(12), .WAIT_STATES(WS)) dut (
        .clk(clk), .rst(rst), .wd(wd), .rd(rd), .size(size), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready), .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
    );

    data_ram_target #(.BASE_ADDR(BASE), .ADDR_BITS(12), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .wd(1'b0), .rd(rd0), .size(SIZE_WORD), .addr(BASE), .wdata(32'h0),
        .rdata(rdata0), .ready(ready0), .busy(busy0), .done(done0), .err(err0), .dbg_state(dbg_state0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: every done/err pulse must match the oldest prediction.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (!rst) begin
            chk("ready_vs_status", {31'b0, ready}, {31'b0, !(busy || done || err)});
            if (done || err) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_response done=%0b err=%0b (cycle %0d)", done, err, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_cycle", {16'b0, cyc[15:0]}, {16'b0, e[48:33]});
                    chk("resp_err", {31'b0, err}, {31'b0, e[32]});
                    chk("resp_done", {31'b0, done}, {31'b0, !e[32]});
                    if (!e[32]) chk("rdata", rdata, e[31:0]);
                end
            end
        end
    end

    // Present one request for one edge and record what the model predicts for it.
    task automatic issue(input logic w, input logic r, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] d);
        int          guard = 0;
        logic [31:0] off, val;
        int          nb;
        bit          in_range, legal;
        while (ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (ready !== 1'b1) chk("ready_timeout", {31'b0, ready}, 32'd1);
        off      = a - BASE;
        in_range = (a >= BASE) && (off < 32'd4096);
        nb       = 1 << sz;
        legal    = !(w && r) && (sz != SIZE_RSVD) && ((off % nb) == 0);
        if (in_range) begin
            if (!legal) begin
                exp_q.push_back({16'(cyc + 1), 1'b1, 32'b0});
            end else if (w) begin
                for (int i = 0; i < nb; i++) model_mem[off + i] = d[8*i +: 8];
                exp_q.push_back({16'(cyc + 2 + WS), 1'b0, last_rd});
            end else begin
                val = '0;
                for (int i = 0; i < nb; i++) val[8*i +: 8] = model_mem[off + i];
                last_rd = val;
                exp_q.push_back({16'(cyc + 2 + WS), 1'b0, val});
            end
        end
        wd = w; rd = r; size = sz; addr = a; wdata = d;
        @(posedge clk); #1;
        wd = 1'b0; rd = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 32'd0);
    endtask

    task automatic check_quiet(input string name);
        chk({name, "_ready"}, {31'b0, ready}, 32'd1);
        chk({name, "_busy"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  sz;
        logic        w;
        logic [31:0] off;
        int          sel;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'b0, ready}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_state", {30'b0, dbg_state}, {30'b0, ST_IDLE});
        rst = 1'b0;

        // Zero-wait build with rd held high: IDLE, ACCESS, DONE repeating.
        rd0 = 1'b1;
        for (int k = 0; k < 12; k++) begin
            chk("ws0_ready", {31'b0, ready0}, {31'b0, (k % 3) == 0});
            chk("ws0_done", {31'b0, done0}, {31'b0, (k % 3) == 2});
            chk("ws0_err", {31'b0, err0}, 32'd0);
            @(posedge clk); #1;
        end
        rd0 = 1'b0;

        for (int i = 0; i < 16; i++) issue(1'b1, 1'b0, SIZE_WORD, BASE + 32'(4 * i), $urandom);
        issue(1'b1, 1'b0, SIZE_WORD, BASE + 32'hFFC, $urandom);

        issue(1'b1, 1'b0, SIZE_WORD, BASE, 32'hDEADBEEF);
        issue(1'b0, 1'b1, SIZE_WORD, BASE, 32'h0);
        drain();
        chk("word_rd_deadbeef", rdata, 32'hDEADBEEF);

        issue(1'b1, 1'b0, SIZE_WORD, BASE, 32'h11223344);
        issue(1'b1, 1'b0, SIZE_BYTE, BASE + 32'd3, 32'h0000005A);
        issue(1'b0, 1'b1, SIZE_WORD, BASE, 32'h0);
        drain();
        chk("byte_merge_word", rdata, 32'h5A223344);
        issue(1'b0, 1'b1, SIZE_BYTE, BASE + 32'd3, 32'h0);
        drain();
        chk("byte_rd_lane3", rdata, 32'h0000005A);

        issue(1'b0, 1'b1, SIZE_HALF, BASE + 32'd1, 32'h0);
        issue(1'b0, 1'b1, SIZE_WORD, BASE + 32'd2, 32'h0);
        issue(1'b1, 1'b1, SIZE_WORD, BASE, 32'hFFFF_FFFF);
        issue(1'b1, 1'b0, SIZE_RSVD, BASE, 32'hFFFF_FFFF);
        issue(1'b0, 1'b1, SIZE_WORD, BASE, 32'h0);
        drain();
        chk("mem_after_illegal", rdata, 32'h5A223344);

        issue(1'b0, 1'b1, SIZE_WORD, 32'h0000_0FFC, 32'h0);
        check_quiet("below_base");
        repeat (3) begin @(posedge clk); #1; check_quiet("below_base_hold"); end
        issue(1'b0, 1'b1, SIZE_WORD, 32'h0000_2000, 32'h0);
        check_quiet("above_span");
        repeat (3) begin @(posedge clk); #1; check_quiet("above_span_hold"); end
        issue(1'b0, 1'b1, SIZE_WORD, 32'h0000_1FFC, 32'h0);
        drain();

        // Reset during WAIT aborts the write; memory keeps its old word.
        wd = 1'b1; size = SIZE_WORD; addr = BASE + 32'h10; wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        wd = 1'b0;
        chk("abort_busy_in_wait", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_ready", {31'b0, ready}, 32'd1);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_err", {31'b0, err}, 32'd0);
        chk("abort_rdata", rdata, 32'd0);
        rst = 1'b0;
        last_rd = '0;
        issue(1'b0, 1'b1, SIZE_WORD, BASE + 32'h10, 32'h0);
        drain();
        chk("abort_mem_kept", rdata, {model_mem[19], model_mem[18], model_mem[17], model_mem[16]});

        for (int n = 0; n < 150; n++) begin
            sel = $urandom_range(0, 9);
            w   = 1'($urandom_range(0, 1));
            sz  = 2'($urandom_range(0, 2));
            off = 32'($urandom_range(0, 63));
            case (sel)
                0:       issue(1'b1, 1'b1, sz, BASE + off, $urandom);
                1:       issue(w, !w, SIZE_RSVD, BASE + off, $urandom);
                2:       issue(w, !w, sz, 32'h0000_3000 + off, $urandom);
                default: issue(w, !w, sz, BASE + off, $urandom);
            endcase
        end
        drain();
        repeat (4) @(posedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
